wave_channel_gen: RTL and testbench
===================================

Name: wave_channel_gen

Overview:
- Parametrised wave-table sound channel; next generation of the CH3 wave block.
- Contains its own wave RAM, frequency-timer period counter, sample-position counter, length counter, DAC gate and volume shifter.
- Sits in the APU next to the other channels. Register-decode logic drives its control strobes; the output feeds the mixer.
- Generalised in sample width, table depth, timer width and length width.

Parameters:
SAMPLE_W, 4, bits per wave sample
NUM_SAMPLES, 32, samples per table; power of two, >=4
FREQ_W, 11, frequency-timer width
LEN_W, 8, length-counter load width
Derived: RAM_W=2*SAMPLE_W; RAM_AW=$clog2(NUM_SAMPLES/2); POS_W=$clog2(NUM_SAMPLES)

Ports:
clk  in  1  APU clock; all flops on rising edge
napu_reset  in  1  asynchronous, active-low reset
tick  in  1  timer clock enable (one clk pulse)
len_tick  in  1  frame-sequencer length enable (256 Hz equivalent)
trig  in  1  trigger strobe (NRx4 bit 7 write)
len_en  in  1  length-counter enable
len_load  in  1  length-load strobe
len_val  in  LEN_W  length value
freq  in  FREQ_W  period register
dac_en  in  1  DAC power (NRx0 bit 7)
vol  in  2  volume code
ram_we  in  1  CPU wave-RAM write strobe
ram_addr  in  RAM_AW  CPU wave-RAM word address
ram_wdata  in  RAM_W  CPU write data
ram_rdata  out  RAM_W  CPU read data (combinational)
active  out  1  channel running
pos  out  POS_W  current sample index
sample_out  out  SAMPLE_W  DAC sample

Behaviour:
- Async reset (napu_reset=0):
  - active=0, pos=0, timer=0, length counter=0, sample buffer=0, sample_out=0.
  - Wave RAM is not reset.
- Wave RAM: NUM_SAMPLES/2 words of RAM_W bits. Sample 2k is the upper half of word k; sample 2k+1 is the lower half.
- CPU access:
  - Inactive: read and write at ram_addr.
  - Active: ram_addr is ignored. Reads return the word at pos>>1; writes land in word pos>>1.
- Timer (FREQ_W bits), on a tick while active:
  - Timer all-ones: timer<=freq; pos<=pos+1, wrapping NUM_SAMPLES-1 -> 0; sample buffer<=RAM sample at the new pos, same edge.
  - Otherwise: timer+1.
  - Period = 2^FREQ_W - freq ticks.
- Trigger (trig=1):
  - With dac_en=1: active<=1; timer<=freq; pos<=0.
  - If the length counter is 0 and len_load=0: counter<=2^LEN_W.
  - The sample buffer is not reloaded; the old sample plays until the first advance.
  - A trigger overrides any tick or len_tick on the same edge.
- Length counter (LEN_W+1 bits):
  - len_load: counter<=2^LEN_W - len_val. Result range 1..2^LEN_W.
  - len_tick with len_en=1 and counter!=0: decrement. Reaching 0 sets active<=0 on the same edge.
  - len_load beats len_tick on the same edge.
  - The counter runs whether active is 0 or 1.
- DAC gate: dac_en=0 forces active<=0 on the next edge. This beats trig and is held for as long as dac_en=0.
- Volume: code 0 mute, 1 full, 2 = sample>>1, 3 = sample>>2 (logical shift).
- sample_out: combinational. Equals the shifted sample buffer when active=1, else 0.
- pos: held when inactive; cleared only by trigger or reset.

Optional Feature:
- Macro: CH3_WAVE_BANK_EN. When defined:
  - RAM doubles to two banks.
  - New inputs: bank_sel (1 bit) and dim64 (1 bit).
  - Playback starts in bank bank_sel.
  - dim64=1: pos widens by 1 bit and playback steps through both banks in sequence (2*NUM_SAMPLES samples).
  - CPU accesses always target bank !bank_sel, including while active.
- Undefined: single bank; those ports are absent.

Test Plan:
- Reset, then RAM words 0..15 written 0x01,0x23,...,0xEF; freq=2046, vol=1, dac_en=1, trig; tick held 1 -> pos advances every 2 ticks; sample_out sequence 0,1,2,...,F,0 (wrap at pos 31 -> 0).
- freq=0x7FF, len_val=0xFE, len_load, len_en=1, trig; pulse len_tick -> active falls on the 2nd len_tick edge; sample_out=0.
- Length counter at 0, trig without len_load; count 256 len_ticks -> active drops exactly on the 256th.
- Active channel at pos=6; CPU read with ram_addr=0 -> ram_rdata = word 3; CPU write of 0xAA -> lands in word 3, word 0 unchanged.
- sample 0xC with vol codes 0,1,2,3 -> sample_out 0x0,0xC,0x6,0x3. dac_en=0 mid-play -> active=0 next edge; trig with dac_en=0 keeps active=0.
- Assert napu_reset mid-play at pos=17 -> active, pos, sample_out go to 0 with no clock edge; wave RAM contents kept.

Source files
------------

// File: rtl/wave_channel_gen.sv
// Wave-table sound channel: wave RAM, frequency timer, sample position, length counter, DAC gate, volume.
// Optional CH3_WAVE_BANK_EN: second RAM bank, bank_sel/dim64 inputs, widened pos for 64-sample playback.
module wave_channel_gen #(
    parameter int SAMPLE_W    = 4,
    parameter int NUM_SAMPLES = 32,
    parameter int FREQ_W      = 11,
    parameter int LEN_W       = 8,
    localparam int RAM_W      = 2 * SAMPLE_W,
    localparam int RAM_AW     = $clog2(NUM_SAMPLES / 2),
    localparam int POS_W      = $clog2(NUM_SAMPLES),
`ifdef CH3_WAVE_BANK_EN
    localparam int PW         = POS_W + 1
`else
    localparam int PW         = POS_W
`endif
) (
    input  logic                clk,
    input  logic                napu_reset,
    input  logic                tick,
    input  logic                len_tick,
    input  logic                trig,
    input  logic                len_en,
    input  logic                len_load,
    input  logic [LEN_W-1:0]    len_val,
    input  logic [FREQ_W-1:0]   freq,
    input  logic                dac_en,
    input  logic [1:0]          vol,
`ifdef CH3_WAVE_BANK_EN
    input  logic                bank_sel,
    input  logic                dim64,
`endif
    input  logic                ram_we,
    input  logic [RAM_AW-1:0]   ram_addr,
    input  logic [RAM_W-1:0]    ram_wdata,
    output logic [RAM_W-1:0]    ram_rdata,
    output logic                active,
    output logic [PW-1:0]       pos,
    output logic [SAMPLE_W-1:0] sample_out
);

    localparam int NUM_WORDS = NUM_SAMPLES / 2;
`ifdef CH3_WAVE_BANK_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif
    localparam int DEPTH   = NUM_WORDS * NUM_BANKS;
    localparam int FULL_AW = $clog2(DEPTH);

    localparam logic [LEN_W:0]    LEN_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0]    LEN_ONE  = (LEN_W + 1)'(1);
    localparam logic [FREQ_W-1:0] TMR_ONE  = FREQ_W'(1);
    localparam logic [PW-1:0]     POS_ONE  = PW'(1);

    logic [RAM_W-1:0]    wave_ram [DEPTH];
    logic [FREQ_W-1:0]   timer;
    logic [LEN_W:0]      len_cnt;
    logic [SAMPLE_W-1:0] sample_buf;
    logic [PW-1:0]       pos_next;
    logic [RAM_AW-1:0]   cpu_word;
    logic [FULL_AW-1:0]  cpu_addr;
    logic [FULL_AW-1:0]  play_addr;
    logic [RAM_W-1:0]    play_word;
    logic [SAMPLE_W-1:0] next_sample;
    logic [SAMPLE_W-1:0] shifted;
    logic                len_dec;
`ifdef CH3_WAVE_BANK_EN
    logic                play_bank;
`endif

    // Position after the next advance; without dim64 the top bit stays clear so playback wraps within one bank.
    always_comb begin
        pos_next = pos + POS_ONE;
`ifdef CH3_WAVE_BANK_EN
        if (!dim64) pos_next[PW-1] = 1'b0;
`endif
    end

    assign cpu_word = active ? pos[POS_W-1:1] : ram_addr;

`ifdef CH3_WAVE_BANK_EN
    assign play_addr = {play_bank ^ pos_next[POS_W], pos_next[POS_W-1:1]};
    assign cpu_addr  = {~bank_sel, cpu_word};
`else
    assign play_addr = pos_next[POS_W-1:1];
    assign cpu_addr  = cpu_word;
`endif

    assign play_word   = wave_ram[play_addr];
    assign next_sample = pos_next[0] ? play_word[SAMPLE_W-1:0] : play_word[RAM_W-1:SAMPLE_W];
    assign ram_rdata   = wave_ram[cpu_addr];

    always_ff @(posedge clk) begin
        if (ram_we) wave_ram[cpu_addr] <= ram_wdata;
    end

    assign len_dec = len_tick && len_en && (len_cnt != '0);

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            active     <= 1'b0;
            pos        <= '0;
            timer      <= '0;
            len_cnt    <= '0;
            sample_buf <= '0;
`ifdef CH3_WAVE_BANK_EN
            play_bank  <= 1'b0;
`endif
        end else begin
            // Length counter: load beats trigger reload, trigger suppresses the same-edge decrement.
            if (len_load) begin
                len_cnt <= LEN_FULL - {1'b0, len_val};
            end else if (trig) begin
                if (len_cnt == '0) len_cnt <= LEN_FULL;
            end else if (len_dec) begin
                len_cnt <= len_cnt - LEN_ONE;
            end

            if (trig) begin
                if (dac_en) begin
                    timer <= freq;
                    pos   <= '0;
`ifdef CH3_WAVE_BANK_EN
                    play_bank <= bank_sel;
`endif
                end
            end else if (tick && active) begin
                if (&timer) begin
                    timer      <= freq;
                    pos        <= pos_next;
                    sample_buf <= next_sample;
                end else begin
                    timer <= timer + TMR_ONE;
                end
            end

            if (!dac_en) begin
                active <= 1'b0;
            end else if (trig) begin
                active <= 1'b1;
            end else if (len_dec && !len_load && (len_cnt == LEN_ONE)) begin
                active <= 1'b0;
            end
        end
    end

    always_comb begin
        case (vol)
            2'd1:    shifted = sample_buf;
            2'd2:    shifted = sample_buf >> 1;
            2'd3:    shifted = sample_buf >> 2;
            default: shifted = '0;
        endcase
        sample_out = active ? shifted : '0;
    end

endmodule

// File: tb/tb_wave_channel_gen.sv
// Directed bench for wave_channel_gen with a scoreboard queue of expected observations.
module tb_wave_channel_gen;

    localparam int SAMPLE_W    = 4;
    localparam int NUM_SAMPLES = 32;
    localparam int FREQ_W      = 11;
    localparam int LEN_W       = 8;
    localparam int RAM_W       = 8;
    localparam int RAM_AW      = 4;
    localparam int POS_W       = 5;

    logic                clk = 1'b0;
    logic                napu_reset;
    logic                tick;
    logic                len_tick;
    logic                trig;
    logic                len_en;
    logic                len_load;
    logic [LEN_W-1:0]    len_val;
    logic [FREQ_W-1:0]   freq;
    logic                dac_en;
    logic [1:0]          vol;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [RAM_W-1:0]    ram_wdata;
    logic [RAM_W-1:0]    ram_rdata;
    logic                active;
    logic [POS_W-1:0]    pos;
    logic [SAMPLE_W-1:0] sample_out;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    wave_channel_gen #(
        .SAMPLE_W    (SAMPLE_W),
        .NUM_SAMPLES (NUM_SAMPLES),
        .FREQ_W      (FREQ_W),
        .LEN_W       (LEN_W)
    ) dut (
        .clk        (clk),
        .napu_reset (napu_reset),
        .tick       (tick),
        .len_tick   (len_tick),
        .trig       (trig),
        .len_en     (len_en),
        .len_load   (len_load),
        .len_val    (len_val),
        .freq       (freq),
        .dac_en     (dac_en),
        .vol        (vol),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .active     (active),
        .pos        (pos),
        .sample_out (sample_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            e.tag = "scoreboard_underflow";
            e.val = 32'hFFFF_FFFF;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    initial begin
        logic [3:0] vol_exp [4];
        int unsigned p;

        vol_exp[0] = 4'h0; vol_exp[1] = 4'hC; vol_exp[2] = 4'h6; vol_exp[3] = 4'h3;

        napu_reset = 1'b0; tick = 1'b0; len_tick = 1'b0; trig = 1'b0;
        len_en = 1'b0; len_load = 1'b0; len_val = '0; freq = '0; dac_en = 1'b0;
        vol = 2'd0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;

        // Reset state
        #3;
        push("rst_active", 0); push("rst_pos", 0); push("rst_sample", 0);
        pop_check(32'(active)); pop_check(32'(pos)); pop_check(32'(sample_out));
        step(); step();
        napu_reset = 1'b1;
        step();

        // Load wave RAM with samples 0..F repeating
        for (int k = 0; k < 16; k++) begin
            ram_we    = 1'b1;
            ram_addr  = 4'(k);
            ram_wdata = {4'(2 * k), 4'(2 * k + 1)};
            step();
        end
        ram_we = 1'b0;
        ram_addr = 4'd5;  push("rd_idle_w5", 32'hAB);  #1; pop_check(32'(ram_rdata));
        ram_addr = 4'd15; push("rd_idle_w15", 32'hEF); #1; pop_check(32'(ram_rdata));

        // Playback at two ticks per sample, including wrap 31 -> 0
        freq = 11'd2046; vol = 2'd1; dac_en = 1'b1; trig = 1'b1;
        push("trig_active", 1); push("trig_pos", 0); push("trig_sample", 0);
        step();
        trig = 1'b0;
        pop_check(32'(active)); pop_check(32'(pos)); pop_check(32'(sample_out));
        tick = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            p = (c / 2) % 32;
            push($sformatf("play_pos_%0d", c), p);
            push($sformatf("play_sample_%0d", c), p % 16);
            step();
            pop_check(32'(pos)); pop_check(32'(sample_out));
        end
        tick = 1'b0;

        // Length load of 0xFE with trigger: two length ticks to expire; buffer not reloaded by trigger
        freq = 11'h7FF; len_val = 8'hFE; len_load = 1'b1; len_en = 1'b1; trig = 1'b1;
        push("len_trig_active", 1); push("len_trig_pos", 0); push("trig_keeps_buf", 1);
        step();
        len_load = 1'b0; trig = 1'b0;
        pop_check(32'(active)); pop_check(32'(pos)); pop_check(32'(sample_out));
        len_tick = 1'b1; push("len_tick1_active", 1); step(); len_tick = 1'b0; pop_check(32'(active));
        step();
        len_tick = 1'b1; push("len_tick2_active", 0); push("len_tick2_sample", 0);
        step();
        len_tick = 1'b0;
        pop_check(32'(active)); pop_check(32'(sample_out));

        // Trigger with counter at zero reloads 256
        trig = 1'b1; push("full_trig_active", 1); step(); trig = 1'b0; pop_check(32'(active));
        len_tick = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            push($sformatf("full_len_%0d", i), (i < 256) ? 1 : 0);
            step();
            pop_check(32'(active));
        end
        len_tick = 1'b0; len_en = 1'b0;

        // CPU access while active redirects to word pos>>1
        trig = 1'b1; step(); trig = 1'b0;
        push("cpu_pos6", 6); push("cpu_sample6", 6);
        tick = 1'b1;
        for (int i = 0; i < 6; i++) step();
        tick = 1'b0;
        pop_check(32'(pos)); pop_check(32'(sample_out));
        ram_addr = 4'd0; push("rd_active_w3", 32'h67); #1; pop_check(32'(ram_rdata));
        ram_we = 1'b1; ram_wdata = 8'hAA; push("rd_after_wr", 32'hAA);
        step();
        ram_we = 1'b0;
        pop_check(32'(ram_rdata));
        dac_en = 1'b0; push("dac_off_active", 0); push("dac_off_sample", 0);
        step();
        pop_check(32'(active)); pop_check(32'(sample_out));
        ram_addr = 4'd0; push("rd_idle_w0_kept", 32'h01); #1; pop_check(32'(ram_rdata));
        ram_addr = 4'd3; push("rd_idle_w3_new", 32'hAA);  #1; pop_check(32'(ram_rdata));

        // Volume codes on sample 0xC, then DAC gate mid-play and gated trigger
        dac_en = 1'b1; trig = 1'b1; step(); trig = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 12; i++) step();
        tick = 1'b0;
        push("vol_pos12", 12); pop_check(32'(pos));
        for (int v = 0; v < 4; v++) begin
            vol = 2'(v);
            push($sformatf("vol_code_%0d", v), 32'(vol_exp[v]));
            #1;
            pop_check(32'(sample_out));
        end
        vol = 2'd1; tick = 1'b1; dac_en = 1'b0;
        push("gate_midplay_active", 0);
        step();
        pop_check(32'(active));
        trig = 1'b1; push("gated_trig_active", 0); push("gated_trig_sample", 0);
        step();
        trig = 1'b0; tick = 1'b0;
        pop_check(32'(active)); pop_check(32'(sample_out));

        // Asynchronous reset mid-play at pos 17
        dac_en = 1'b1; trig = 1'b1; step(); trig = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 17; i++) step();
        tick = 1'b0;
        push("pre_rst_pos17", 17); push("pre_rst_sample", 1);
        pop_check(32'(pos)); pop_check(32'(sample_out));
        #2;
        napu_reset = 1'b0;
        push("async_rst_active", 0); push("async_rst_pos", 0); push("async_rst_sample", 0);
        #1;
        pop_check(32'(active)); pop_check(32'(pos)); pop_check(32'(sample_out));
        ram_addr = 4'd6; push("ram_kept_w6", 32'hCD); #1; pop_check(32'(ram_rdata));
        ram_addr = 4'd3; push("ram_kept_w3", 32'hAA); #1; pop_check(32'(ram_rdata));
        ram_addr = 4'd8; push("ram_kept_w8", 32'h01); #1; pop_check(32'(ram_rdata));
        step();
        napu_reset = 1'b1;
        step();

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
